// File: rtl/mux_4x1_usg_dec_tri_core.sv
// 4-to-1 multiplexer built from a 2-to-4 decoder and four tri-state buffers
// sharing one internal bus. The bus value, the decoder output and a valid
// flag are captured in registers on every rising clock edge.
// When the mux is disabled the bus floats, so Y holds its last value.
module mux_4x1_usg_dec_tri_core #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       S1,
  input  logic       S0,
  input  logic [3:0] I,
  output logic       Y,
  output logic [3:0] dec_out,
  output logic       y_valid
);

  // One-hot decode of the select lines, gated by the enable.
  // A disabled decoder yields all zeros, so no buffer can drive the bus.
  function automatic logic [3:0] decode_2to4(input logic enable, input logic [1:0] sel);
    logic [3:0] onehot;
    onehot = 4'b0000;
    if (enable) begin
      case (sel)
        2'b00:   onehot = 4'b0001;
        2'b01:   onehot = 4'b0010;
        2'b10:   onehot = 4'b0100;
        2'b11:   onehot = 4'b1000;
        default: onehot = 4'b0000;
      endcase
    end else begin
      onehot = 4'b0000;
    end
    return onehot;
  endfunction

  logic [1:0] sel_s;
  logic [3:0] dec_s;
  tri         bus_s;

  logic       y_q;
  logic       y_d;
  logic [3:0] dec_q;
  logic [3:0] dec_d;
  logic       valid_q;
  logic       valid_d;

  assign sel_s = {S1, S0};
  assign dec_s = decode_2to4(en, sel_s);

  // Four tri-state buffers on one bus. The decoder is one-hot or zero,
  // so at most one buffer is ever enabled and contention cannot occur.
  genvar k;
  generate
    for (k = 0; k < 4; k++) begin : g_tri_buf
      assign bus_s = dec_s[k] ? I[k] : 1'bz;
    end
  endgenerate

  // Next-state selection: load the bus when enabled, otherwise hold Y.
  // The bus is never sampled while it floats, so Y cannot pick up Z/X.
  always_comb begin
    y_d     = y_q;
    dec_d   = 4'b0000;
    valid_d = 1'b0;
    if (en) begin
      y_d     = bus_s;
      dec_d   = dec_s;
      valid_d = 1'b1;
    end else begin
      y_d     = y_q;
      dec_d   = 4'b0000;
      valid_d = 1'b0;
    end
  end

  // Output registers with synchronous reset taking priority over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= RST_VAL;
      dec_q   <= 4'b0000;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      dec_q   <= dec_d;
      valid_q <= valid_d;
    end
  end

  assign Y       = y_q;
  assign dec_out = dec_q;
  assign y_valid = valid_q;

endmodule

// File: tb/tb_mux_4x1_usg_dec_tri_core.sv
// Self-checking bench for mux_4x1_usg_dec_tri_core: directed scenarios,
// an exhaustive select/data sweep and randomized traffic, all compared
// against a behavioural model of the multiplexer.
module tb_mux_4x1_usg_dec_tri_core;

  logic       clk;
  logic       rst;
  logic       en;
  logic       S1;
  logic       S0;
  logic [3:0] I;
  logic       Y;
  logic [3:0] dec_out;
  logic       y_valid;

  int compared;
  int mismatched;

  // Behavioural model state
  logic       m_y;
  logic [3:0] m_dec;
  logic       m_valid;

  mux_4x1_usg_dec_tri_core #(.RST_VAL(1'b0)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .S1      (S1),
    .S0      (S0),
    .I       (I),
    .Y       (Y),
    .dec_out (dec_out),
    .y_valid (y_valid)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Apply inputs, clock one edge, advance the model, compare all outputs.
  task automatic step(input string tag, input logic r, input logic e,
                      input logic [1:0] s, input logic [3:0] d);
    int idx;
    rst = r;
    en  = e;
    {S1, S0} = s;
    I   = d;
    @(posedge clk);
    #1;
    idx = int'(s);
    if (r) begin
      m_y     = 1'b0;
      m_dec   = 4'b0000;
      m_valid = 1'b0;
    end else if (e) begin
      m_y     = d[idx];
      m_dec   = 4'b0000;
      m_dec[idx] = 1'b1;
      m_valid = 1'b1;
    end else begin
      m_dec   = 4'b0000;
      m_valid = 1'b0;
    end
    check({tag, ".Y"},       {3'b000, Y},       {3'b000, m_y});
    check({tag, ".dec_out"}, dec_out,           m_dec);
    check({tag, ".y_valid"}, {3'b000, y_valid}, {3'b000, m_valid});
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    m_y = 1'b0; m_dec = 4'b0000; m_valid = 1'b0;
    rst = 1'b1; en = 1'b1; {S1, S0} = 2'b00; I = 4'b1111;

    // Reset for two cycles with all data high and enable set
    step("rst0", 1'b1, 1'b1, 2'b00, 4'b1111);
    step("rst1", 1'b1, 1'b1, 2'b11, 4'b1111);

    // Each channel selected with only its own bit set
    step("ch0", 1'b0, 1'b1, 2'b00, 4'b0001);
    step("ch1", 1'b0, 1'b1, 2'b01, 4'b0010);
    step("ch2", 1'b0, 1'b1, 2'b10, 4'b0100);
    step("ch3", 1'b0, 1'b1, 2'b11, 4'b1000);

    // Non-selected bits must not leak into Y
    step("iso0", 1'b0, 1'b1, 2'b10, 4'b1011);
    step("iso1", 1'b0, 1'b1, 2'b10, 4'b0100);

    // Disable holds Y while data drops
    step("hold0", 1'b0, 1'b0, 2'b10, 4'b0000);
    step("hold1", 1'b0, 1'b0, 2'b01, 4'b1111);

    // Inputs changing between edges must not disturb the registered outputs
    rst = 1'b0; en = 1'b1; {S1, S0} = 2'b01; I = 4'b0000;
    #3;
    check("midcyc.Y",       {3'b000, Y},       {3'b000, m_y});
    check("midcyc.dec_out", dec_out,           m_dec);
    check("midcyc.y_valid", {3'b000, y_valid}, {3'b000, m_valid});

    // Reset priority over enable, then normal load after release
    step("rstpri", 1'b1, 1'b1, 2'b11, 4'b1000);
    step("rstrel", 1'b0, 1'b1, 2'b11, 4'b1000);

    // Simultaneous select and data change
    step("swap", 1'b0, 1'b1, 2'b00, 4'b0001);
    step("swap", 1'b0, 1'b1, 2'b01, 4'b0000);

    // Exhaustive sweep of selects and data
    for (int s = 0; s < 4; s++) begin
      for (int d = 0; d < 16; d++) begin
        step("exh", 1'b0, 1'b1, 2'(s), 4'(d));
      end
    end

    // Randomized traffic with occasional disables and resets
    for (int n = 0; n < 300; n++) begin
      step("rnd", ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
